instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter FETCH_NUM, default `FETCH_NUM (2): maximum words written per cycle.
REQ-002 Parameter ISSUE_NUM, default 2: maximum words presented to and consumed by decode per cycle.
REQ-003 Parameter DEPTH, default 8: entry count; SHALL be a power of two and at least 2*FETCH_NUM.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  discard all contents (mispredict or exception redirect).
REQ-007 push_valid  in  1  fetch stage offers a bundle.
REQ-008 push_num  in  $clog2(FETCH_NUM+1)  count of valid lanes in the bundle, lanes 0..push_num-1.
REQ-009 push_data  in  FETCH_NUM x fetch_entry_t  per lane: instr[31:0], vaddr[31:0], iaddr_ex flag.
REQ-010 push_ready  out  1  at least FETCH_NUM free entries; drives the PC generator hold as ~push_ready.
REQ-011 pop_num  in  $clog2(ISSUE_NUM+1)  entries consumed by decode this cycle.
REQ-012 out_data  out  ISSUE_NUM x fetch_entry_t  oldest ISSUE_NUM entries, in program order.
REQ-013 out_valid  out  ISSUE_NUM  out_valid[i]=1 iff count>i.
REQ-014 count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 The block SHALL hold head, tail (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and count registers.
REQ-016 A push SHALL be accepted when push_valid & push_ready; lane i (i<push_num) is written to mem[(tail+i) mod DEPTH]; tail and count advance by push_num.
REQ-017 push_valid with push_num=0 SHALL change no state.
REQ-018 push_ready SHALL be (DEPTH-count)>=FETCH_NUM, computed from registered count only, with no credit for a same-cycle pop.
REQ-019 out_data[i] SHALL be combinational from mem[(head+i) mod DEPTH]; out_data lanes with out_valid[i]=0 are don't-care.
REQ-020 Effective pop SHALL be min(pop_num, count); head advances by the effective pop and count decreases by it.
REQ-021 Simultaneous push and pop SHALL yield count_next = count + accepted push_num - effective pop.
REQ-022 A pushed entry SHALL become visible on out_data no earlier than the cycle after the push; there is no bypass path.
REQ-023 flush SHALL set head, tail and count to 0 on the next edge and SHALL override any same-cycle push and pop.
REQ-024 Wrap-around SHALL be transparent: a bundle straddling index DEPTH-1 to 0 SHALL keep lane order.
REQ-025 Memory contents SHALL need no reset; only pointers and count are reset.

Reset
REQ-026 While rst_n=0, head=tail=count=0, out_valid=0 and push_ready=1, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all entries; the first cycle after release SHALL behave as an empty queue.

Structure
REQ-028 fetch_entry_t and `FETCH_NUM SHALL be defined in the shared cpu_defs package/header; the block SHALL define no new shared types.
REQ-029 The block SHALL be a single module with no sub-module; mem SHALL be a flop array indexed by the pointers.

Verification
REQ-030 Reset, then push 2 words (vaddr 0xBFC00000, 0xBFC00004) with pop_num=0 -> next cycle count=2, out_valid=2'b11, out_data[0].vaddr=0xBFC00000.
REQ-031 Push 2 per cycle with no pop from empty, DEPTH=8 -> push_ready=0 once count=7 or 8; a push offered while push_ready=0 is ignored; count never exceeds 8.
REQ-032 With count=7, head=1, tail=0: push 2 and pop 2 in the same cycle -> push rejected (push_ready=0), count=5, head=3.
REQ-033 Fill with head=tail=6, push 2 lanes, then pop until empty -> entries emerge as lane0 at index 6, lane1 at index 7, then the wrapped entries at 0, 1, in program order.
REQ-034 With count=5, assert flush together with push 2 and pop 1 -> next cycle count=0, out_valid=0, push_ready=1.
REQ-035 With count=1, pop_num=2 -> count=0; head advances by 1 only.

Source files
------------

// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Shared CPU definitions used across the front end.
//   - `FETCH_NUM : number of instruction words the fetch stage delivers per cycle
//   - fetch_entry_t : one fetched instruction word plus its virtual address and
//                     the instruction-address exception flag raised by fetch
// -----------------------------------------------------------------------------
`ifndef FETCH_NUM
`define FETCH_NUM 2
`endif

package cpu_defs;

  typedef struct packed {
    logic [31:0] instr;     // raw instruction word
    logic [31:0] vaddr;     // virtual address the word was fetched from
    logic        iaddr_ex;  // instruction address exception detected at fetch
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Circular instruction queue between the fetch stage and decode.  Fetch writes
//   up to FETCH_NUM words per cycle; decode sees the oldest ISSUE_NUM words in
//   program order and consumes up to ISSUE_NUM of them per cycle.
//
//   Parameters
//     FETCH_NUM  words written per cycle (max)
//     ISSUE_NUM  words presented to / consumed by decode per cycle (max)
//     DEPTH      entry count; must be a power of two and >= 2*FETCH_NUM
//
//   Ports
//     clk         clock, all state updates on the rising edge
//     rst_n       asynchronous active-low reset (pointers and count only)
//     flush       drop all contents; wins over a same-cycle push and pop
//     push_valid  fetch offers a bundle
//     push_num    number of valid lanes in the bundle (lanes 0..push_num-1)
//     push_data   per-lane fetch entries
//     push_ready  at least FETCH_NUM free entries (registered count only)
//     pop_num     entries consumed by decode this cycle
//     out_data    oldest ISSUE_NUM entries, lane 0 is the oldest
//     out_valid   out_valid[i] = (count > i)
//     count       current occupancy
// -----------------------------------------------------------------------------
`ifndef FETCH_NUM
`define FETCH_NUM 2
`endif

module instr_fetch_queue
  import cpu_defs::*;
#(
  parameter int FETCH_NUM = `FETCH_NUM,
  parameter int ISSUE_NUM = 2,
  parameter int DEPTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push_valid,
  input  logic [$clog2(FETCH_NUM+1)-1:0] push_num,
  input  fetch_entry_t                   push_data [FETCH_NUM],
  output logic                           push_ready,
  input  logic [$clog2(ISSUE_NUM+1)-1:0] pop_num,
  output fetch_entry_t                   out_data  [ISSUE_NUM],
  output logic [ISSUE_NUM-1:0]           out_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PN_W  = $clog2(FETCH_NUM+1);

  // ---------------------------------------------------------------------------
  // State: entry storage (no reset) plus head/tail pointers and occupancy.
  // Pointers are exactly PTR_W bits wide so that wrap-around is free modulo
  // DEPTH; count is kept separately so full and empty are distinguishable.
  // ---------------------------------------------------------------------------
  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_free;
  logic             w_push_ready;
  logic [PN_W-1:0]  w_push_len;
  logic             w_push_fire;
  logic [CNT_W-1:0] w_push_amt;
  logic [CNT_W-1:0] w_pop_amt;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W-1:0] w_wr_idx [FETCH_NUM];
  logic [PTR_W-1:0] w_rd_idx [ISSUE_NUM];

  // ---------------------------------------------------------------------------
  // Push side.  Readiness looks only at the registered count: a pop in the same
  // cycle earns no credit, which keeps push_ready (and hence the PC-generator
  // hold) off the decode-to-fetch combinational path.
  // ---------------------------------------------------------------------------
  assign w_free       = CNT_W'(DEPTH) - r_count;
  assign w_push_ready = (w_free >= CNT_W'(FETCH_NUM));

  // A lane count beyond the bundle width cannot be honoured; saturate it so a
  // malformed push_num never advances tail past the lanes actually written.
  assign w_push_len  = (push_num > PN_W'(FETCH_NUM)) ? PN_W'(FETCH_NUM) : push_num;
  assign w_push_fire = push_valid & w_push_ready;
  assign w_push_amt  = w_push_fire ? CNT_W'(w_push_len) : '0;

  // ---------------------------------------------------------------------------
  // Pop side.  Decode may ask for more than is held; only what is present is
  // removed, so head never overtakes tail.
  // ---------------------------------------------------------------------------
  assign w_pop_amt = (32'(pop_num) < 32'(r_count)) ? CNT_W'(pop_num) : r_count;

  // ---------------------------------------------------------------------------
  // Next-state arithmetic.  Pointer sums are truncated to PTR_W, which is the
  // modulo-DEPTH wrap because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  assign w_count_next = r_count + w_push_amt - w_pop_amt;
  assign w_head_next  = r_head + PTR_W'(w_pop_amt);
  assign w_tail_next  = r_tail + PTR_W'(w_push_amt);

  // Per-lane write and read indices; lane order survives the DEPTH-1 -> 0 wrap.
  generate
    for (genvar gi = 0; gi < FETCH_NUM; gi++) begin : g_wr_idx
      assign w_wr_idx[gi] = r_tail + PTR_W'(gi);
    end
    for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : g_rd_idx
      assign w_rd_idx[gi] = r_head + PTR_W'(gi);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pointer / count registers.  flush has priority over push and pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage.  Contents need no reset: an entry is only ever observed
  // after it has been written, because out_valid is derived from count.
  // The write is suppressed under flush so a discarded bundle never lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push_fire && !flush) begin
      for (int i = 0; i < FETCH_NUM; i++) begin
        if (PN_W'(i) < w_push_len) begin
          r_mem[w_wr_idx[i]] <= push_data[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.  out_data reads straight from storage at head, so a word pushed
  // this cycle appears only after the edge that writes it (no bypass).
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : g_out
      assign out_data[gi]  = r_mem[w_rd_idx[gi]];
      assign out_valid[gi] = (32'(r_count) > gi);
    end
  endgenerate

  assign push_ready = w_push_ready;
  assign count      = r_count;

  // Occupancy can never exceed the storage size.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) (32'(r_count) <= DEPTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
`timescale 1ns/1ps
module tb_instr_fetch_queue;
  import cpu_defs::*;

  localparam int DEPTH = 8;
  localparam int FN    = 2;
  localparam int IN    = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         push_valid = 1'b0;
  logic [1:0]   push_num = '0;
  fetch_entry_t push_data [FN];
  logic         push_ready;
  logic [1:0]   pop_num = '0;
  fetch_entry_t out_data [IN];
  logic [IN-1:0] out_valid;
  logic [3:0]   count;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .FETCH_NUM (FN),
    .ISSUE_NUM (IN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_num   (push_num),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_num    (pop_num),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .count      (count)
  );

  fetch_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic fresh_data();
    for (int i = 0; i < FN; i++) begin
      push_data[i].instr    = $urandom;
      push_data[i].vaddr    = 32'h0040_0000 + 32'(seq) * 4;
      push_data[i].iaddr_ex = ($urandom_range(0, 7) == 0);
      seq++;
    end
  endtask

  // One transaction: drive, let combinational outputs settle, compare against
  // the scoreboard (current state only), update the scoreboard, take the edge.
  task automatic step(input bit pv, input int pn, input int pop, input bit fl);
    int sz, eff;
    bit rdy, acc;
    fetch_entry_t exp_e;
    push_valid = pv;
    push_num   = 2'(pn);
    pop_num    = 2'(pop);
    flush      = fl;
    #2;
    sz  = sb_q.size();
    rdy = ((DEPTH - sz) >= FN);
    chk("count", 128'(count), 128'(sz));
    chk("out_valid", 128'(out_valid), {126'b0, sz > 1, sz > 0});
    chk("push_ready", 128'(push_ready), 128'(rdy));
    eff = (pop < sz) ? pop : sz;
    acc = pv && rdy;
    for (int i = 0; i < eff; i++) begin
      exp_e = sb_q.pop_front();
      chk("pop_data", 128'(out_data[i]), 128'(exp_e));
    end
    for (int i = eff; i < IN; i++) begin
      if (i < sz) chk("head_data", 128'(out_data[i]), 128'(sb_q[i-eff]));
    end
    if (fl) sb_q.delete();
    else if (acc) for (int i = 0; i < pn; i++) sb_q.push_back(push_data[i]);
    $display("txn pv=%0d pn=%0d pop=%0d flush=%0d accepted=%0d occupancy_next=%0d",
             pv, pn, pop, fl, acc, sb_q.size());
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    push_num   = '0;
    pop_num    = '0;
    flush      = 1'b0;
  endtask

  task automatic push_pop(input bit pv, input int pn, input int pop, input bit fl);
    fresh_data();
    step(pv, pn, pop, fl);
  endtask

  initial begin
    fresh_data();

    // Reset values, asynchronously while rst_n is low
    #3;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(push_ready), 128'(1));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // First push after reset, boot addresses
    push_data[0].instr = 32'h3c08_bfc0; push_data[0].vaddr = 32'hBFC0_0000; push_data[0].iaddr_ex = 1'b0;
    push_data[1].instr = 32'h2508_0010; push_data[1].vaddr = 32'hBFC0_0004; push_data[1].iaddr_ex = 1'b0;
    step(1, 2, 0, 0);
    chk("boot_count", 128'(count), 128'(2));
    chk("boot_valid", 128'(out_valid), 128'(2'b11));
    chk("boot_vaddr0", 128'(out_data[0].vaddr), 128'(32'hBFC0_0000));
    push_pop(0, 0, 2, 0);

    // Fill two per cycle with no pop; refuse once fewer than two slots remain
    push_pop(1, 2, 0, 0);
    push_pop(1, 2, 0, 0);
    push_pop(1, 2, 0, 0);
    push_pop(1, 1, 0, 0);      // count 7
    push_pop(1, 2, 0, 0);      // ignored
    push_pop(1, 2, 0, 0);      // ignored
    chk("full7_count", 128'(count), 128'(7));
    push_pop(0, 0, 1, 0);      // 6
    push_pop(1, 2, 0, 0);      // 8
    push_pop(1, 2, 0, 0);      // ignored
    chk("full8_count", 128'(count), 128'(8));

    // count=7, head=1, tail=0: simultaneous push 2 / pop 2 -> push rejected
    push_pop(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) push_pop(1, 2, 0, 0);
    push_pop(0, 0, 1, 0);
    push_pop(1, 2, 2, 0);
    chk("nocredit_count", 128'(count), 128'(5));

    // push_valid with zero lanes changes nothing
    push_pop(1, 0, 0, 0);
    chk("zero_push_count", 128'(count), 128'(5));

    // Flush overrides a same-cycle push and pop
    push_pop(1, 2, 1, 1);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(push_ready), 128'(1));

    // Over-pop with one entry: head moves by one only
    push_pop(1, 1, 0, 0);
    push_pop(0, 0, 2, 0);
    chk("overpop_count", 128'(count), 128'(0));
    push_pop(1, 2, 0, 0);
    push_pop(0, 0, 1, 0);

    // Wrap: bring head=tail=6, then a bundle at 6,7 and one at 0,1
    push_pop(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) push_pop(1, 2, 0, 0);
    for (int k = 0; k < 3; k++) push_pop(0, 0, 2, 0);
    push_pop(1, 2, 0, 0);
    push_pop(1, 2, 0, 0);
    for (int k = 0; k < 4; k++) push_pop(0, 0, 1, 0);
    chk("wrap_empty", 128'(count), 128'(0));

    // Reset asserted mid-operation
    push_pop(1, 2, 0, 0);
    push_pop(1, 2, 1, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_count", 128'(count), 128'(0));
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_ready", 128'(push_ready), 128'(1));
    sb_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    push_pop(1, 2, 0, 0);
    push_pop(0, 0, 1, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      push_pop($urandom_range(0, 3) != 0, $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 24) == 0);
    end

    // Drain
    for (int k = 0; k < 6; k++) push_pop(0, 0, 2, 0);
    chk("final_count", 128'(count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
